// File: rtl/reg_file_mp_if.sv
// Register file access bundle: clear request, N_RD read ports, one write port, ready status.
interface reg_file_mp_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned N_RD   = 2
);
    logic                     i_clr;
    logic [N_RD-1:0]          i_rd_en;
    logic [N_RD*ADDR_W-1:0]   i_rd_addr;
    logic [N_RD*DATA_W-1:0]   o_rd_dat;
    logic                     i_wr_en;
    logic [ADDR_W-1:0]        i_wr_addr;
    logic [DATA_W-1:0]        i_wr_dat;
    logic                     o_ready;

    modport master (
        output i_clr, i_rd_en, i_rd_addr, i_wr_en, i_wr_addr, i_wr_dat,
        input  o_rd_dat, o_ready
    );

    modport slave (
        input  i_clr, i_rd_en, i_rd_addr, i_wr_en, i_wr_addr, i_wr_dat,
        output o_rd_dat, o_ready
    );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with registered reads, write-first forwarding
// and a hardware clear sequencer that zeroes the array after reset or on request.
module reg_file_mp #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned N_RD     = 2,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    reg_file_mp_if.slave  bus
);
    localparam int unsigned       DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   cnt;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                mem_we;
    logic [ADDR_W-1:0]   mem_wa;
    logic [DATA_W-1:0]   mem_wd;
    logic                wr_zero;
    logic [DATA_W-1:0]   rd_val [N_RD];

    assign wr_zero = ZERO_REG && (bus.i_wr_addr == '0);

    // Array write port is shared between the clear sequencer and writeback.
    always_comb begin
        mem_we = 1'b0;
        mem_wa = bus.i_wr_addr;
        mem_wd = bus.i_wr_dat;
        if (state == CLEAR) begin
            mem_we = 1'b1;
            mem_wa = cnt;
            mem_wd = '0;
        end else if (bus.i_wr_en && !bus.i_clr && !wr_zero) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    // Uncleared cells may hold garbage, so every read during CLEAR yields zero.
    for (genvar p = 0; p < N_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              fwd;
        assign ra  = bus.i_rd_addr[p*ADDR_W +: ADDR_W];
        assign fwd = (state == IDLE) && bus.i_wr_en && (bus.i_wr_addr == ra);
        assign rd_val[p] = ((ZERO_REG && (ra == '0)) || (state == CLEAR)) ? '0 :
                           fwd ? bus.i_wr_dat : mem[ra];
    end

    // Sequencer state, clear counter, ready flag and registered read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= CLEAR;
            cnt          <= '0;
            bus.o_ready  <= 1'b0;
            bus.o_rd_dat <= '0;
        end else begin
            for (int unsigned p = 0; p < N_RD; p++) begin
                if (bus.i_rd_en[p]) begin
                    bus.o_rd_dat[p*DATA_W +: DATA_W] <= rd_val[p];
                end
            end
            case (state)
                CLEAR: begin
                    if (bus.i_clr) begin
                        cnt <= '0;
                    end else if (cnt == LAST) begin
                        cnt         <= '0;
                        state       <= IDLE;
                        bus.o_ready <= 1'b1;
                    end else begin
                        cnt <= cnt + ADDR_W'(1);
                    end
                end
                IDLE: begin
                    if (bus.i_clr) begin
                        state       <= CLEAR;
                        cnt         <= '0;
                        bus.o_ready <= 1'b0;
                    end
                end
                default: begin
                    state <= CLEAR;
                    cnt   <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench: two register files (ZERO_REG=1 and ZERO_REG=0) driven by identical stimulus.
module tb_reg_file_mp;
    logic clk;
    logic rst;

    reg_file_mp_if #(.DATA_W(32), .ADDR_W(5), .N_RD(2)) ifa ();
    reg_file_mp_if #(.DATA_W(32), .ADDR_W(5), .N_RD(2)) ifb ();

    reg_file_mp #(.DATA_W(32), .ADDR_W(5), .N_RD(2), .ZERO_REG(1'b1)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa)
    );
    reg_file_mp #(.DATA_W(32), .ADDR_W(5), .N_RD(2), .ZERO_REG(1'b0)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb)
    );

    assign ifb.i_clr     = ifa.i_clr;
    assign ifb.i_rd_en   = ifa.i_rd_en;
    assign ifb.i_rd_addr = ifa.i_rd_addr;
    assign ifb.i_wr_en   = ifa.i_wr_en;
    assign ifb.i_wr_addr = ifa.i_wr_addr;
    assign ifb.i_wr_dat  = ifa.i_wr_dat;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [31:0] qa [$];
    logic [31:0] qb [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic pop_chk(input bit b, input int p);
        logic [31:0] e;
        logic [31:0] act;
        if (b) begin
            act = ifb.o_rd_dat[p*32 +: 32];
            if (qb.size() == 0) chk($sformatf("rd_b_p%0d_noexp", p), 32'(qb.size()), 32'd1);
            else begin e = qb.pop_front(); chk($sformatf("rd_b_p%0d", p), act, e); end
        end else begin
            act = ifa.o_rd_dat[p*32 +: 32];
            if (qa.size() == 0) chk($sformatf("rd_a_p%0d_noexp", p), 32'(qa.size()), 32'd1);
            else begin e = qa.pop_front(); chk($sformatf("rd_a_p%0d", p), act, e); end
        end
    endtask

    // Monitor: every enabled read port presents its data one edge later.
    logic [1:0] mon_en;
    logic       mon_rst;
    always begin
        @(posedge clk);
        mon_en  = ifa.i_rd_en;
        mon_rst = rst;
        #1;
        if (!mon_rst) begin
            for (int p = 0; p < 2; p++) begin
                if (mon_en[p]) begin
                    pop_chk(1'b0, p);
                    pop_chk(1'b1, p);
                end
            end
        end
    end

    task automatic push(input logic [1:0] re, input logic [31:0] ea0, input logic [31:0] ea1,
                        input logic [31:0] eb0, input logic [31:0] eb1);
        if (re[0]) begin qa.push_back(ea0); qb.push_back(eb0); end
        if (re[1]) begin qa.push_back(ea1); qb.push_back(eb1); end
    endtask

    task automatic cyc(input bit we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [1:0] re, input logic [4:0] a0, input logic [4:0] a1,
                       input logic [31:0] ea0, input logic [31:0] ea1,
                       input logic [31:0] eb0, input logic [31:0] eb1);
        @(negedge clk);
        ifa.i_wr_en   = we;
        ifa.i_wr_addr = wa;
        ifa.i_wr_dat  = wd;
        ifa.i_rd_en   = re;
        ifa.i_rd_addr = {a1, a0};
        push(re, ea0, ea1, eb0, eb1);
    endtask

    task automatic idle();
        cyc(1'b0, 5'd0, 32'd0, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    endtask

    // Starts a clear (rst or i_clr), optionally re-triggers it after edge re_n,
    // and counts edges until o_ready rises. Also tries a write of x3 and a read of x31 mid-clear.
    task automatic run_clear(input bit start_rst, input int re_n, input bit re_rst,
                             input int exp_n, input string nm);
        int n;
        @(negedge clk);
        ifa.i_wr_en = 1'b0;
        ifa.i_rd_en = 2'b00;
        if (start_rst) rst = 1'b1; else ifa.i_clr = 1'b1;
        n = 0;
        while (n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) begin
                chk({nm, "_ready_lo_a"}, 32'(ifa.o_ready), 32'd0);
                chk({nm, "_ready_lo_b"}, 32'(ifb.o_ready), 32'd0);
                if (start_rst) begin
                    chk({nm, "_rst_rd_a"}, ifa.o_rd_dat[31:0], 32'd0);
                    chk({nm, "_rst_rd_b"}, ifb.o_rd_dat[63:32], 32'd0);
                end
            end
            if (ifa.o_ready) break;
            rst           = 1'b0;
            ifa.i_clr     = 1'b0;
            ifa.i_wr_en   = (n == 10);
            ifa.i_wr_addr = 5'd3;
            ifa.i_wr_dat  = 32'h0000_00AA;
            ifa.i_rd_en   = (n == 5) ? 2'b10 : 2'b00;
            ifa.i_rd_addr = {5'd31, 5'd0};
            if (n == 5) push(2'b10, 32'd0, 32'd0, 32'd0, 32'd0);
            if (n == re_n) begin
                if (re_rst) rst = 1'b1; else ifa.i_clr = 1'b1;
            end
        end
        chk({nm, "_cycles"}, 32'(n), 32'(exp_n));
        chk({nm, "_ready_b"}, 32'(ifb.o_ready), 32'd1);
        ifa.i_wr_en = 1'b0;
        ifa.i_rd_en = 2'b00;
    endtask

    initial begin
        rst = 1'b0;
        ifa.i_clr = 1'b0;
        ifa.i_wr_en = 1'b0;
        ifa.i_wr_addr = '0;
        ifa.i_wr_dat = '0;
        ifa.i_rd_en = '0;
        ifa.i_rd_addr = '0;

        run_clear(1'b1, 0, 1'b0, 33, "por");

        for (int a = 1; a < 32; a++)
            cyc(1'b0, 5'd0, 32'd0, 2'b11, 5'(a), 5'(32 - a), 32'd0, 32'd0, 32'd0, 32'd0);

        cyc(1'b1, 5'd5, 32'hDEAD_BEEF, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        cyc(1'b0, 5'd0, 32'd0, 2'b01, 5'd5, 5'd0, 32'hDEAD_BEEF, 32'd0, 32'hDEAD_BEEF, 32'd0);

        cyc(1'b1, 5'd7, 32'h1234_5678, 2'b11, 5'd7, 5'd7,
            32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678);

        cyc(1'b1, 5'd0, 32'hFFFF_FFFF, 2'b01, 5'd0, 5'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0);
        cyc(1'b0, 5'd0, 32'd0, 2'b01, 5'd0, 5'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0);

        cyc(1'b0, 5'd0, 32'd0, 2'b10, 5'd7, 5'd5, 32'd0, 32'hDEAD_BEEF, 32'd0, 32'hDEAD_BEEF);
        idle();
        chk("hold_a_p0", ifa.o_rd_dat[31:0], 32'd0);
        chk("hold_b_p0", ifb.o_rd_dat[31:0], 32'hFFFF_FFFF);

        for (int i = 1; i < 32; i++)
            cyc(1'b1, 5'(i), 32'(i), 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        cyc(1'b0, 5'd0, 32'd0, 2'b11, 5'd3, 5'd31, 32'd3, 32'd31, 32'd3, 32'd31);
        cyc(1'b0, 5'd0, 32'd0, 2'b11, 5'd0, 5'd17, 32'd0, 32'd17, 32'hFFFF_FFFF, 32'd17);
        idle();

        run_clear(1'b0, 0, 1'b0, 33, "clr");
        cyc(1'b0, 5'd0, 32'd0, 2'b11, 5'd3, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        cyc(1'b0, 5'd0, 32'd0, 2'b11, 5'd31, 5'd17, 32'd0, 32'd0, 32'd0, 32'd0);

        cyc(1'b1, 5'd9, 32'd9, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        cyc(1'b1, 5'd31, 32'd31, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        idle();
        run_clear(1'b0, 20, 1'b0, 53, "clr_restart");
        cyc(1'b0, 5'd0, 32'd0, 2'b11, 5'd9, 5'd31, 32'd0, 32'd0, 32'd0, 32'd0);

        cyc(1'b1, 5'd31, 32'd31, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        cyc(1'b0, 5'd0, 32'd0, 2'b01, 5'd31, 5'd0, 32'd31, 32'd0, 32'd31, 32'd0);
        idle();
        run_clear(1'b0, 20, 1'b1, 53, "rst_restart");
        cyc(1'b0, 5'd0, 32'd0, 2'b11, 5'd31, 5'd3, 32'd0, 32'd0, 32'd0, 32'd0);

        idle();
        idle();
        chk("qa_left", 32'(qa.size()), 32'd0);
        chk("qb_left", 32'(qb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
